// File: rtl/maj_net_tt_gen_if.sv
// maj_net_tt_gen_if: config/start/result bus of the MAJ-3 truth-table generator
// master (host): drives cfg_we/cfg_addr/cfg_data, start, tt_ready
// slave  (dut) : drives cfg_err, busy, tt, tt_valid
interface maj_net_tt_gen_if #(
  parameter int N_IN    = 7,
  parameter int N_GATES = 8
);
  localparam int SELW = $clog2(1 + N_IN + N_GATES);
  localparam int OPW  = 3 * (SELW + 1);
  localparam int AW   = $clog2(N_GATES + 1);
  localparam int TT_W = 1 << N_IN;
  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [OPW-1:0]  cfg_data;
  logic            cfg_err;
  logic            start;
  logic            busy;
  logic [TT_W-1:0] tt;
  logic            tt_valid;
  logic            tt_ready;
  modport master (
    output cfg_we, cfg_addr, cfg_data, start, tt_ready,
    input  cfg_err, busy, tt, tt_valid
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, tt_ready,
    output cfg_err, busy, tt, tt_valid
  );
endinterface

// File: rtl/maj_net_tt_gen.sv
// maj_net_tt_gen: programmable MAJ-3 network that sweeps all input minterms into a truth table
// clk, rst_n (async active-low); bus: slave side of maj_net_tt_gen_if
module maj_net_tt_gen #(
  parameter int N_IN    = 7,
  parameter int N_GATES = 8
) (
  input logic             clk,
  input logic             rst_n,
  maj_net_tt_gen_if.slave bus
);
  localparam int NS   = 1 + N_IN + N_GATES;
  localparam int SELW = $clog2(NS);
  localparam int FW   = SELW + 1;
  localparam int OPW  = 3 * FW;
  localparam int AW   = $clog2(N_GATES + 1);
  localparam int GW   = (N_GATES > 1) ? $clog2(N_GATES) : 1;
  localparam int TT_W = 1 << N_IN;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          r_state, w_nstate;
  logic [N_IN:0]   r_m, w_nm;
  logic [TT_W-1:0] r_tt, w_ntt;
  logic [OPW-1:0]  r_gate [N_GATES];
  logic [FW-1:0]   r_out;
  logic            r_busy, r_valid, r_err;
  logic [NS-1:0]   w_sig;
  logic            w_eval, w_ok;
  logic [SELW-1:0] w_sa, w_sb, w_sc;
  logic [SELW:0]   w_lim;
  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
  function automatic logic opnd(input logic [NS-1:0] s, input logic [FW-1:0] f);
    return s[f[SELW-1:0]] ^ f[SELW];
  endfunction
  // Gates resolve in index order; each only sees lower indices, so one pass suffices
  always_comb begin
    w_sig = '0;
    w_sig[N_IN:1] = r_m[N_IN-1:0];
    for (int g = 0; g < N_GATES; g++)
      w_sig[SELW'(N_IN + 1 + g)] = maj(opnd(w_sig, r_gate[GW'(g)][0 +: FW]),
                                       opnd(w_sig, r_gate[GW'(g)][FW +: FW]),
                                       opnd(w_sig, r_gate[GW'(g)][2*FW +: FW]));
    w_eval = opnd(w_sig, r_out);
  end
  assign w_sa  = bus.cfg_data[0 +: SELW];
  assign w_sb  = bus.cfg_data[FW +: SELW];
  assign w_sc  = bus.cfg_data[2*FW +: SELW];
  assign w_lim = (bus.cfg_addr < AW'(N_GATES)) ? FW'(N_IN + 1) + FW'(bus.cfg_addr) : FW'(NS);
  // Writes coinciding with start are rejected so the sweep sees a stable network
  assign w_ok  = (r_state == IDLE) && !bus.start && (bus.cfg_addr <= AW'(N_GATES)) &&
                 ({1'b0, w_sa} < w_lim) &&
                 ((bus.cfg_addr == AW'(N_GATES)) || (({1'b0, w_sb} < w_lim) && ({1'b0, w_sc} < w_lim)));
  always_comb begin
    w_nstate = r_state;
    w_nm     = r_m;
    w_ntt    = r_tt;
    case (r_state)
      IDLE: if (bus.start) begin
        w_nstate = RUN;
        w_nm     = '0;
        w_ntt    = '0;
      end
      RUN: begin
        w_ntt[r_m[N_IN-1:0]] = w_eval;
        w_nm     = r_m + 1'b1;
        w_nstate = w_nm[N_IN] ? DONE : RUN;
      end
      DONE: w_nstate = bus.tt_ready ? IDLE : DONE;
      default: w_nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_tt    <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_out   <= '0;
      for (int g = 0; g < N_GATES; g++) r_gate[GW'(g)] <= '0;
    end else begin
      r_state <= w_nstate;
      r_m     <= w_nm;
      r_tt    <= w_ntt;
      r_busy  <= w_nstate != IDLE;
      r_valid <= w_nstate == DONE;
      r_err   <= bus.cfg_we && !w_ok;
      if (bus.cfg_we && w_ok) begin
        if (bus.cfg_addr == AW'(N_GATES)) r_out <= bus.cfg_data[FW-1:0];
        else r_gate[bus.cfg_addr[GW-1:0]] <= bus.cfg_data;
      end
    end
  end
  assign bus.tt       = r_tt;
  assign bus.tt_valid = r_valid;
  assign bus.busy     = r_busy;
  assign bus.cfg_err  = r_err;
endmodule

// File: tb/tb_maj_net_tt_gen.sv
// tb_maj_net_tt_gen: directed self-checking bench for maj_net_tt_gen
module tb_maj_net_tt_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  time t0;
  logic [127:0] e800, part, snap;
  always #5 clk = ~clk;
  maj_net_tt_gen_if #(.N_IN(7), .N_GATES(8)) bus ();
  maj_net_tt_gen #(.N_IN(7), .N_GATES(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  function automatic logic [14:0] mk(bit ic, int sc, bit ib, int sb, bit ia, int sa);
    return {ic, 4'(sc), ib, 4'(sb), ia, 4'(sa)};
  endfunction
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(int addr, logic [14:0] d, bit exp_err, string tag);
    @(negedge clk);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 4'(addr);
    bus.cfg_data = d;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    chk(tag, bus.cfg_err, exp_err);
    @(negedge clk);
    chk({tag, "_low"}, bus.cfg_err, 0);
  endtask
  task automatic go();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t0 = $time;
    chk("busy_rise", bus.busy, 1);
  endtask
  task automatic fin(string tag, logic [127:0] exp, int hold);
    int n = 0;
    logic [127:0] s;
    while (!bus.tt_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 128'(($time - t0) / 10), 128);
    chk({tag, "_tt"}, bus.tt, exp);
    s = bus.tt;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, bus.tt_valid, 1);
      chk({tag, "_hold_tt"}, bus.tt, s);
    end
    bus.tt_ready = 1'b1;
    @(negedge clk);
    bus.tt_ready = 1'b0;
    chk({tag, "_valid_clr"}, bus.tt_valid, 0);
    chk({tag, "_busy_clr"}, bus.busy, 0);
  endtask
  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.start = 1'b0;
    bus.tt_ready = 1'b0;
    e800 = {8{16'hE800}};
    #2;
    chk("rst_tt", bus.tt, 0);
    chk("rst_valid", bus.tt_valid, 0);
    chk("rst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go();
    fin("default", 0, 0);
    wr(8, mk(0, 0, 0, 0, 0, 1), 0, "wr_out_x0");
    go();
    fin("out_x0", {16{8'hAA}}, 0);
    wr(8, mk(0, 0, 0, 0, 1, 1), 0, "wr_out_nx0");
    go();
    fin("out_nx0", {16{8'h55}}, 0);
    wr(0, mk(0, 3, 0, 2, 0, 1), 0, "wr_g0");
    wr(8, mk(0, 0, 0, 0, 0, 8), 0, "wr_out_g0");
    go();
    fin("maj012", {16{8'hE8}}, 0);
    wr(0, mk(0, 3, 0, 2, 1, 1), 0, "wr_g0_inv");
    go();
    fin("maj_inv", {16{8'hD4}}, 0);
    wr(0, mk(0, 3, 0, 2, 0, 1), 0, "wr_g0_back");
    wr(1, mk(0, 0, 0, 4, 0, 8), 0, "wr_g1");
    wr(8, mk(0, 0, 0, 0, 0, 9), 0, "wr_out_g1");
    go();
    fin("g1", e800, 0);
    wr(0, mk(0, 3, 0, 2, 0, 8), 1, "ill_sel_g0");
    wr(1, mk(0, 9, 0, 4, 0, 8), 1, "ill_selc_g1");
    wr(9, mk(0, 0, 0, 0, 0, 1), 1, "ill_addr");
    go();
    fin("after_ill", e800, 0);
    go();
    repeat (5) @(negedge clk);
    wr(0, mk(1, 3, 1, 2, 1, 1), 1, "run_wr");
    fin("after_run_wr", e800, 0);
    bus.start = 1'b1;
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 4'd8;
    bus.cfg_data = mk(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.cfg_we = 1'b0;
    t0 = $time;
    chk("start_wr_err", bus.cfg_err, 1);
    chk("start_wr_busy", bus.busy, 1);
    fin("b2b", e800, 0);
    go();
    repeat (59) @(negedge clk);
    part = e800 & ((128'd1 << 59) - 128'd1);
    chk("mid_sweep_tt", bus.tt, part);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tt", bus.tt, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_valid", bus.tt_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    go();
    fin("post_rst", 0, 20);
    summary();
  end
  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask
endmodule
